// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues sequential word-aligned instruction requests under a credit limit and
// buffers in-order {pc, instruction} responses in a small FIFO that feeds decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];

    logic          credit_ok;
    logic          req_fire;
    logic          rsp_take;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_next;
    logic [31:0]   redirect_target;
    logic [1:0]    redirect_lsb_unused;

    // Valid/ready: a transfer happens on any rising edge where valid && ready are both high.
    // Requests are only offered when every outstanding request plus the buffered entries
    // still leaves a FIFO slot, so non-discarded responses can always be written.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_EXT;
    assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    assign push     = rsp_take && (discard == '0) && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;

    assign outstanding_next    = outstanding + CW'(req_fire) - CW'(rsp_take);
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused = redirect_pc[1:0];

    assign out_valid       = (fifo_count != '0);
    assign out_instruction = out_valid ? data_mem[rd_ptr] : 32'h0;
    assign out_pc          = out_valid ? pc_mem[rd_ptr] : 32'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                fetch_pc   <= redirect_target;
                rsp_pc     <= redirect_target;
                discard    <= outstanding_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_take && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model, {pc, instruction} scoreboard,
// a per-cycle vector table for the credit-limit fill, and directed redirect/reset sequences.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clock;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic        req_ready;
        logic        out_rdy;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_out_valid;
        logic [31:0] exp_out_pc;
    } vec_t;

    mem_req_t    mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc;
    int          cyc;
    int          lat_min;
    int          lat_max;
    logic        data_const;
    int          checks;
    int          passes;

    logic        d_reset_n;
    logic        d_req_ready;
    logic        d_out_ready;
    logic        d_redirect;
    logic [31:0] d_redirect_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (data_const) return 32'h0000_0013;
        return (addr * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // driver + memory model + scoreboard, one call per clock cycle
    task automatic cycle();
        @(posedge clock);
        #1;
        reset_n        = d_reset_n;
        imem_req_ready = d_req_ready;
        out_ready      = d_out_ready;
        redirect_valid = d_redirect;
        redirect_pc    = d_redirect_pc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clock);
        if (!reset_n) begin
            exp_q.delete();
            exp_fetch_pc = RESET_PC;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mem_req_t r;
                check32("req_addr", imem_req_addr, exp_fetch_pc);
                r.addr = imem_req_addr;
                r.due  = cyc + $urandom_range(lat_min, lat_max);
                mem_q.push_back(r);
                exp_q.push_back({exp_fetch_pc, mem_data(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL stale_pop: got pc %h with nothing expected (cycle %0d)", out_pc, cyc);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check32("pop_pc", out_pc, e[63:32]);
                    check32("pop_instr", out_instruction, e[31:0]);
                end
            end
            if (redirect_valid) begin
                check32("redirect_req_valid", {31'b0, imem_req_valid}, 32'd0);
                exp_q.delete();
                exp_fetch_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check32({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check32({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check32({tag, "_out_instr"}, out_instruction, 32'd0);
        check32({tag, "_out_pc"}, out_pc, 32'd0);
    endtask

    task automatic reset_dut();
        d_reset_n   = 1'b0;
        d_req_ready = 1'b0;
        d_out_ready = 1'b0;
        d_redirect  = 1'b0;
        mem_q.delete();
        cycle();
        cycle();
        check_reset_outputs("reset");
        d_reset_n = 1'b1;
    endtask

    vec_t vecs[11];

    initial begin
        checks = 0;
        passes = 0;
        cyc = 0;
        lat_min = 1;
        lat_max = 1;
        data_const = 1'b0;
        exp_fetch_pc = RESET_PC;
        reset_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        d_redirect_pc = 32'h0;

        // credit-limit fill with decode stalled, then release one pop at a time
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};

        // streaming with constant instruction, 1-cycle memory
        data_const = 1'b1;
        lat_min = 1; lat_max = 1;
        reset_dut();
        d_req_ready = 1'b1;
        d_out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (c < 2) begin
                check32("stream_fill_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                check32("stream_out_valid", {31'b0, out_valid}, 32'd1);
                check32("stream_out_pc", out_pc, 32'(c - 2) * 32'd4);
                check32("stream_out_instr", out_instruction, 32'h0000_0013);
            end
        end
        data_const = 1'b0;

        // vector table
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            d_req_ready = vecs[i].req_ready;
            d_out_ready = vecs[i].out_rdy;
            cycle();
            check32("vec_req_valid", {31'b0, imem_req_valid}, {31'b0, vecs[i].exp_req_valid});
            check32("vec_req_addr", imem_req_addr, vecs[i].exp_req_addr);
            check32("vec_out_valid", {31'b0, out_valid}, {31'b0, vecs[i].exp_out_valid});
            if (vecs[i].exp_out_valid) check32("vec_out_pc", out_pc, vecs[i].exp_out_pc);
        end
        for (int i = 0; i < 10; i++) cycle();

        // redirect with two requests in flight, 3-cycle memory
        lat_min = 3; lat_max = 3;
        reset_dut();
        d_out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            d_req_ready   = (c != 2);
            d_redirect    = (c == 2);
            d_redirect_pc = 32'h0000_0103;
            cycle();
            if (c == 3) begin
                check32("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
                check32("redir_req_addr", imem_req_addr, 32'h0000_0100);
            end
            if (c >= 3 && c <= 6) check32("redir_gap_out_valid", {31'b0, out_valid}, 32'd0);
            if (c == 7) begin
                check32("redir_first_valid", {31'b0, out_valid}, 32'd1);
                check32("redir_first_pc", out_pc, 32'h0000_0100);
                check32("redir_first_instr", out_instruction, mem_data(32'h0000_0100));
            end
        end
        d_redirect = 1'b0;

        // redirect coinciding with a response and a pop, 2-cycle memory
        lat_min = 2; lat_max = 2;
        reset_dut();
        d_out_ready = 1'b1;
        d_req_ready = 1'b1;
        d_redirect_pc = 32'h0000_0202;
        for (int c = 0; c < 10; c++) begin
            d_redirect = (c == 3);
            cycle();
            if (c == 3) begin
                check32("coinc_pop_valid", {31'b0, out_valid}, 32'd1);
                check32("coinc_pop_pc", out_pc, 32'h0);
            end
            if (c == 4) begin
                check32("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
                check32("coinc_req_addr", imem_req_addr, 32'h0000_0200);
            end
            if (c >= 4 && c <= 6) check32("coinc_out_valid", {31'b0, out_valid}, 32'd0);
            if (c == 7) begin
                check32("coinc_first_valid", {31'b0, out_valid}, 32'd1);
                check32("coinc_first_pc", out_pc, 32'h0000_0200);
            end
        end
        d_redirect = 1'b0;

        // random backpressure and redirects against the scoreboard
        lat_min = 1; lat_max = 4;
        reset_dut();
        for (int c = 0; c < 1000; c++) begin
            d_req_ready   = ($urandom_range(0, 3) != 0);
            d_out_ready   = ($urandom_range(0, 2) != 0);
            d_redirect    = ($urandom_range(0, 39) == 0);
            d_redirect_pc = $urandom & 32'h0000_FFFF;
            cycle();
        end
        d_redirect  = 1'b0;
        d_req_ready = 1'b0;
        d_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) cycle();
        check32("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check32("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // reset mid-burst with three requests in flight; stale responses arrive afterwards
        lat_min = 4; lat_max = 4;
        reset_dut();
        d_out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            d_req_ready = (c < 3) || (c >= 7);
            d_out_ready = (c >= 7);
            d_reset_n   = !(c == 3 || c == 4);
            cycle();
            if (c == 3) check_reset_outputs("midreset");
            if (c == 5 || c == 7) begin
                check32("postreset_req_valid", {31'b0, imem_req_valid}, 32'd1);
                check32("postreset_req_addr", imem_req_addr, RESET_PC);
            end
            if (c >= 5 && c <= 11) check32("postreset_out_valid", {31'b0, out_valid}, 32'd0);
            if (c == 12) begin
                check32("postreset_first_valid", {31'b0, out_valid}, 32'd1);
                check32("postreset_first_pc", out_pc, RESET_PC);
                check32("postreset_first_instr", out_instruction, mem_data(RESET_PC));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the decode/control stage. Generates sequential word-aligned PCs, issues requests to instruction memory over a valid/ready channel and accepts in-order responses. Buffers {pc, instruction} pairs in a small FIFO that feeds decode through a valid/ready handshake. On a redirect from decode (jump or taken branch) it flushes the FIFO, restarts at the target and discards responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
FIFO_DEPTH, 4, entries in the fetch buffer and the maximum number of outstanding requests; power of two, >=2.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  fetch address; bits[1:0] always 0.
imem_rsp_valid  input  1  response valid; responses arrive in order, at least 1 cycle after acceptance.
imem_rsp_data  input  32  fetched instruction word.
redirect_valid  input  1  decode requests a PC change this cycle.
redirect_pc  input  32  redirect target; bits[1:0] are ignored and treated as 0.
out_valid  output  1  FIFO head holds a valid instruction.
out_ready  input  1  decode consumes the head this cycle.
out_instruction  output  32  instruction at the FIFO head.
out_pc  output  32  PC of out_instruction.

Behaviour:
- Reset (async assert, synchronous release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instruction=0, out_pc=0.
- Counters: outstanding and discard are each $clog2(FIFO_DEPTH+1) bits wide.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). This guarantees a FIFO slot for every non-discarded response, so the FIFO never overflows.
- Request handshake: imem_req_addr = fetch_pc. On valid&&ready, fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
- imem_req_valid may drop without a handshake only in a redirect cycle or when the credit limit is reached. The memory must tolerate this.
- Response handling: a response decrements outstanding.
  - If discard>0, the data is dropped and discard decrements.
  - Otherwise {rsp_pc, imem_rsp_data} is written to the FIFO tail and rsp_pc += 4.
  - An accepted request and a response in the same cycle leave outstanding unchanged.
- Output: out_valid = FIFO non-empty; out_instruction/out_pc come from the head, held stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready. Push and pop in the same cycle are allowed at any occupancy.
  - Latency: a response written at edge E appears on out_valid after E (earliest: request accepted at cycle N, response N+1, out_valid N+2).
- Redirect (cycle where redirect_valid=1), applied at the edge:
  - FIFO flushed; a pop in the same cycle is ignored.
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2],2'b00}.
  - discard = outstanding after this cycle's update, i.e. minus a response arriving this cycle, which is itself dropped. No request is accepted this cycle.
  - out_valid=0 the following cycle.
  - Back-to-back redirects: the latest target wins and discard is recomputed from the current outstanding count (no double counting).
- Response while outstanding==0 is a protocol error: ignored, and outstanding does not underflow.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH; full/empty is distinguished by an extra pointer bit or by a count.

Test Plan:
- Reset release, always-ready memory, 1-cycle latency returning 32'h0000_0013 for every address, out_ready=1 -> requests at 0x0,0x4,0x8,…; out_pc sequence 0x0,0x4,0x8 on consecutive cycles after 2-cycle fill; no gaps.
- out_ready=0, memory ready -> exactly 4 requests issued (addresses 0x0–0xC), then imem_req_valid=0. FIFO fills to 4; out_pc holds 0x0. Raise out_ready -> one new request per pop.
- Memory latency 3, redirect_valid with redirect_pc=0x103 while 2 requests are outstanding -> those 2 responses dropped, next request addr 0x100, first out_pc=0x100 with its data; no stale instruction reaches out.
- Redirect in the same cycle as a response and a pop -> response dropped, FIFO empty next cycle, discard equals remaining outstanding, fetch resumes at target.
- imem_req_ready toggled pseudo-randomly and out_ready randomly for 1000 cycles against a reference PC model -> out_pc strictly +4 between redirects, data matches memory, FIFO never overflows.
- reset_n asserted mid-burst with 3 outstanding -> all outputs return to reset values immediately; after release the first request is RESET_PC and late stale responses are ignored.
